round_controller: RTL
=====================

# round_controller

Game-flow controller for the duck-hunt datapath. It sequences each bird's life from launch through flight to shot-down or escape, and enforces the per-bird shot budget and the flight timeout. It keeps per-round bird and hit counts and decides between round advance and game over. It sits between the input/hit-detection logic and the bird counter, sprite and score logic: it drives the 3-bit `state` and the `flew_away` level those consume.

## Interface
Parameters:
- BIRDS_PER_ROUND, 3, birds launched per round
- SHOTS_PER_BIRD, 3, shots allowed per bird (1..3)
- FLIGHT_FRAMES, 600, frames before an unshot bird escapes
- FALL_FRAMES, 60, frames spent in FALLING
- ESCAPE_FRAMES, 60, frames spent in ESCAPE
- ROUND_END_FRAMES, 120, frames spent in ROUND_END
- MIN_HITS, 2, hits needed per round to advance

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high
- frame_clk  in  1  vsync-rate level; rising edge = one frame tick
- start  in  1  start key level; rising edge = start request
- trigger  in  1  gun trigger level; rising edge = one shot
- hit  in  1  crosshair-over-bird flag, sampled only on a shot cycle
- state  out  3  FSM state encoding
- launch  out  1  one-cycle pulse; spawn a new bird
- flew_away  out  1  high for the whole of ESCAPE
- shot_down  out  1  high for the whole of FALLING
- shots_left  out  2  remaining shots for the current bird
- birds_done  out  8  birds finished this round
- hits  out  8  birds hit this round
- round  out  8  current round number, 1-based
- score  out  16  total score
- game_over  out  1  high in GAME_OVER

## Operation
- Edge detectors on frame_clk, start and trigger: one flop each, async reset to 0; edge = in & ~prev. An input held high at reset release therefore yields one edge on the first cycle.
- State encoding: IDLE=0, LAUNCH=1, FLYING=2, FALLING=3, ESCAPE=4, ROUND_END=5, GAME_OVER=6. Code 7 is unreachable and recovers to IDLE.
- IDLE / GAME_OVER, on start edge: go to LAUNCH. score=0, round=1, hits=0, birds_done=0.
- LAUNCH: lasts exactly one cycle. launch=1, shots_left=SHOTS_PER_BIRD, frame counter=0. Next state is FLYING.
- FLYING, processed in priority order each cycle:
  1. Shot edge with shots_left>0: decrement shots_left.
     - If hit: go to FALLING; hits+1, birds_done+1, score+100 (saturating at 0xFFFF).
     - Else if shots_left becomes 0: go to ESCAPE; birds_done+1.
  2. Otherwise, on frame edge: increment the frame counter. When the count reaches FLIGHT_FRAMES, go to ESCAPE; birds_done+1.
  - A shot and a frame edge in the same cycle: the shot wins and the frame tick is dropped.
  - Shot edges when shots_left=0 are ignored.
- FALLING / ESCAPE: count frame edges from 0. At FALL_FRAMES / ESCAPE_FRAMES, go to ROUND_END if birds_done==BIRDS_PER_ROUND, else to LAUNCH.
- ROUND_END: after ROUND_END_FRAMES frame edges:
  - if hits>=MIN_HITS: round+1 (saturating at 255), hits=0, birds_done=0, go to LAUNCH;
  - else go to GAME_OVER.
- Trigger and hit are ignored outside FLYING. Start is ignored outside IDLE and GAME_OVER.
- Frame counter is 16 bits and is cleared on every state entry.

## Timing
- All outputs are registered. An edge sampled in cycle n produces its state and counter update visible in cycle n+1.
- launch is high only during the single LAUNCH cycle, so FLYING starts 2 cycles after the enabling event.
- flew_away rises on ESCAPE entry and stays high for ESCAPE_FRAMES frame ticks, so any downstream edge detector sees exactly one edge per escape.
- Reset values: state=IDLE, launch=0, flew_away=0, shot_down=0, shots_left=0, birds_done=0, hits=0, round=0, score=0, game_over=0.
- Reset asserted mid-operation returns everything to those values immediately (asynchronously). Nothing persists.

## Test plan
Use FLIGHT_FRAMES=4, FALL_FRAMES=ESCAPE_FRAMES=2, ROUND_END_FRAMES=2, defaults otherwise.
- Reset, then start pulse -> launch high for exactly 1 cycle; state 0->1->2; round=1, shots_left=3.
- In FLYING, trigger edge with hit=1 -> next cycle state=3, shot_down=1, hits=1, birds_done=1, score=100; 2 frame ticks later state=1.
- Three trigger edges with hit=0 -> shots_left goes 2,1,0, then state=4 and flew_away=1 for 2 frames; a 4th trigger has no effect.
- No shots, 4 frame ticks -> ESCAPE. Trigger edge with hit=1 coincident with the 4th frame tick -> FALLING, not ESCAPE.
- Round with 2 hits and 1 escape -> ROUND_END, then round=2, hits=0, birds_done=0, launch pulse. Round with 1 hit -> GAME_OVER, game_over=1; start edge -> round=1, score=0.
- Reset asserted during FALLING with score=300 -> all outputs return to reset values within the same cycle. With trigger held high across reset release -> no shot is counted and state stays IDLE.

Source files
------------

// File: rtl/round_controller.sv
// Duck-hunt game-flow controller: sequences each bird from launch to
// shot-down or escape, tracks per-round hits/birds, round advance and game over.
module round_controller #(
    parameter int BIRDS_PER_ROUND  = 3,
    parameter int SHOTS_PER_BIRD   = 3,
    parameter int FLIGHT_FRAMES    = 600,
    parameter int FALL_FRAMES      = 60,
    parameter int ESCAPE_FRAMES    = 60,
    parameter int ROUND_END_FRAMES = 120,
    parameter int MIN_HITS         = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        trigger,
    input  logic        hit,
    output logic [2:0]  state,
    output logic        launch,
    output logic        flew_away,
    output logic        shot_down,
    output logic [1:0]  shots_left,
    output logic [7:0]  birds_done,
    output logic [7:0]  hits,
    output logic [7:0]  round,
    output logic [15:0] score,
    output logic        game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_FLYING    = 3'd2,
        S_FALLING   = 3'd3,
        S_ESCAPE    = 3'd4,
        S_ROUND_END = 3'd5,
        S_GAME_OVER = 3'd6
    } state_e;

    localparam logic [7:0]  BIRDS_L  = 8'(BIRDS_PER_ROUND);
    localparam logic [1:0]  SHOTS_L  = 2'(SHOTS_PER_BIRD);
    localparam logic [15:0] FLIGHT_L = 16'(FLIGHT_FRAMES);
    localparam logic [15:0] FALL_L   = 16'(FALL_FRAMES);
    localparam logic [15:0] ESC_L    = 16'(ESCAPE_FRAMES);
    localparam logic [15:0] RE_L     = 16'(ROUND_END_FRAMES);
    localparam logic [7:0]  MIN_L    = 8'(MIN_HITS);

    logic        frame_prev_q, start_prev_q, trig_prev_q;
    logic        frame_edge, start_edge, trig_edge;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_tick;
    logic [1:0]  shots_q, shots_d;
    logic [7:0]  birds_q, birds_d;
    logic [7:0]  hits_q, hits_d;
    logic [7:0]  round_q, round_d;
    logic [15:0] score_q, score_d;
    logic        launch_q, launch_d;
    logic        flew_q, flew_d;
    logic        down_q, down_d;
    logic        over_q, over_d;

    assign frame_edge = frame_clk & ~frame_prev_q;
    assign start_edge = start & ~start_prev_q;
    assign trig_edge  = trigger & ~trig_prev_q;
    assign cnt_tick   = cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shots_d = shots_q;
        birds_d = birds_q;
        hits_d  = hits_q;
        round_d = round_q;
        score_d = score_q;
        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge) begin
                    state_d = S_LAUNCH;
                    score_d = 16'd0;
                    round_d = 8'd1;
                    hits_d  = 8'd0;
                    birds_d = 8'd0;
                end
            end
            S_LAUNCH: state_d = S_FLYING;
            S_FLYING: begin
                // A consumed shot swallows a coincident frame tick
                if (trig_edge && shots_q != 2'd0) begin
                    shots_d = shots_q - 2'd1;
                    if (hit) begin
                        state_d = S_FALLING;
                        hits_d  = hits_q + 8'd1;
                        birds_d = birds_q + 8'd1;
                        score_d = (score_q > 16'hFF9B) ? 16'hFFFF
                                                       : score_q + 16'd100;
                    end else if (shots_q == 2'd1) begin
                        state_d = S_ESCAPE;
                        birds_d = birds_q + 8'd1;
                    end
                end else if (frame_edge) begin
                    cnt_d = cnt_tick;
                    if (cnt_tick == FLIGHT_L) begin
                        state_d = S_ESCAPE;
                        birds_d = birds_q + 8'd1;
                    end
                end
            end
            S_FALLING, S_ESCAPE: begin
                if (frame_edge) begin
                    cnt_d = cnt_tick;
                    if (cnt_tick == ((state_q == S_FALLING) ? FALL_L : ESC_L))
                        state_d = (birds_q == BIRDS_L) ? S_ROUND_END : S_LAUNCH;
                end
            end
            S_ROUND_END: begin
                if (frame_edge) begin
                    cnt_d = cnt_tick;
                    if (cnt_tick == RE_L) begin
                        if (hits_q >= MIN_L) begin
                            round_d = (round_q == 8'hFF) ? round_q
                                                         : round_q + 8'd1;
                            hits_d  = 8'd0;
                            birds_d = 8'd0;
                            state_d = S_LAUNCH;
                        end else begin
                            state_d = S_GAME_OVER;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = 16'd0;
        if (state_d == S_LAUNCH) shots_d = SHOTS_L;
        launch_d = (state_d == S_LAUNCH);
        flew_d   = (state_d == S_ESCAPE);
        down_d   = (state_d == S_FALLING);
        over_d   = (state_d == S_GAME_OVER);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_prev_q <= 1'b0;
            start_prev_q <= 1'b0;
            trig_prev_q  <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            shots_q      <= 2'd0;
            birds_q      <= 8'd0;
            hits_q       <= 8'd0;
            round_q      <= 8'd0;
            score_q      <= 16'd0;
            launch_q     <= 1'b0;
            flew_q       <= 1'b0;
            down_q       <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            frame_prev_q <= frame_clk;
            start_prev_q <= start;
            trig_prev_q  <= trigger;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shots_q      <= shots_d;
            birds_q      <= birds_d;
            hits_q       <= hits_d;
            round_q      <= round_d;
            score_q      <= score_d;
            launch_q     <= launch_d;
            flew_q       <= flew_d;
            down_q       <= down_d;
            over_q       <= over_d;
        end
    end

    assign state      = state_q;
    assign launch     = launch_q;
    assign flew_away  = flew_q;
    assign shot_down  = down_q;
    assign shots_left = shots_q;
    assign birds_done = birds_q;
    assign hits       = hits_q;
    assign round      = round_q;
    assign score      = score_q;
    assign game_over  = over_q;

endmodule
